// File: rtl/mcycle_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit.
//   WIDTH_DEFAULT : default operand/result width
//   OP_*          : MCycleOp encodings
//   state_t       : controller states
//   cnt_width()   : iteration counter width for a given operand width
package mcycle_pkg;

  localparam int WIDTH_DEFAULT = 32;

  localparam logic [1:0] OP_SMUL = 2'b00;
  localparam logic [1:0] OP_UMUL = 2'b01;
  localparam logic [1:0] OP_SDIV = 2'b10;
  localparam logic [1:0] OP_UDIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    COMPUTING = 2'b01,
    DONE      = 2'b10
  } state_t;

  // One extra bit so the counter can hold WIDTH itself.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_SDIV) || (op == OP_UDIV);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_SMUL) || (op == OP_SDIV);
  endfunction

endpackage

// File: rtl/mcycle_iter.sv
// One combinational iteration of the shared multiply/divide datapath.
//   is_div : 1 = restoring shift-subtract step, 0 = shift-add step
//   hi     : product high word / partial remainder
//   lo     : multiplier bits (shifting out) / dividend bits shifting into quotient
//   opd    : multiplicand / divisor magnitude
//   hi_nx, lo_nx : register values after this step
module mcycle_iter #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] opd,
  output logic [WIDTH-1:0] hi_nx,
  output logic [WIDTH-1:0] lo_nx
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shl;
  logic [WIDTH-1:0] dif;
  logic             ge;

  // Multiply: add multiplicand when the current multiplier bit is set, then
  // shift the whole {carry, hi, lo} right by one.
  assign sum = {1'b0, hi} + {1'b0, (lo[0] ? opd : '0)};

  // Divide: bring the next dividend bit into the partial remainder. The
  // remainder stays below the divisor, so the difference fits in WIDTH bits.
  assign shl = {hi, lo[WIDTH-1]};
  assign ge  = (shl >= {1'b0, opd});
  assign dif = shl[WIDTH-1:0] - opd;

  always_comb begin
    hi_nx = sum[WIDTH:1];
    lo_nx = {sum[0], lo[WIDTH-1:1]};
    if (is_div) begin
      hi_nx = ge ? dif : shl[WIDTH-1:0];
      lo_nx = {lo[WIDTH-2:0], ge};
    end
  end

endmodule

// File: rtl/mcycle_unit.sv
// Iterative multiply/divide unit: one shift-add or shift-subtract step per
// clock, WIDTH steps per operation.
//   CLK, RESETn        : clock, async active-low reset
//   Start, MCycleOp    : request and operation (sampled only in IDLE)
//   Operand1, Operand2 : multiplicand/dividend, multiplier/divisor
//   Result1, Result2   : low product/quotient, high product/remainder
//   Busy               : stall request, high from Start through last step
//
// state     | meaning
// IDLE      | waiting for Start; operands latched on Start
// COMPUTING | one iteration per cycle; results registered on the last one
// DONE      | results valid for one cycle, Start ignored
module mcycle_unit
  import mcycle_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int OP_W  = 2
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             Start,
  input  logic [OP_W-1:0]  MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy
);

  localparam int               CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_t state_q, state_d;

  logic [OP_W-1:0]  op_q;
  logic             s1_q, s2_q;
  logic [WIDTH-1:0] op1_q, opd_q, hi_q, lo_q, res1_q, res2_q;
  logic [CNT_W-1:0] cnt_q;

  logic             start_div, start_sgn, div, sgn, neg;
  logic [WIDTH-1:0] mag1, mag2;
  logic [WIDTH-1:0] hi_nx, lo_nx;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo, rem, fin1, fin2;

  assign start_div = op_is_div(MCycleOp[1:0]);
  assign start_sgn = op_is_signed(MCycleOp[1:0]);
  assign div       = op_is_div(op_q[1:0]);
  assign sgn       = op_is_signed(op_q[1:0]);

  // The -2^(WIDTH-1) magnitude wraps to itself, which as an unsigned
  // magnitude is the right value.
  assign mag1 = (start_sgn && Operand1[WIDTH-1]) ? -Operand1 : Operand1;
  assign mag2 = (start_sgn && Operand2[WIDTH-1]) ? -Operand2 : Operand2;

  mcycle_iter #(.WIDTH(WIDTH)) u_iter (
    .is_div (div),
    .hi     (hi_q),
    .lo     (lo_q),
    .opd    (opd_q),
    .hi_nx  (hi_nx),
    .lo_nx  (lo_nx)
  );

  // Sign fix-up applied to the outcome of the final iteration.
  always_comb begin
    neg  = sgn & (s1_q ^ s2_q);
    prod = {hi_nx, lo_nx};
    if (neg) prod = -prod;
    quo = lo_nx;
    if (neg) quo = -quo;
    rem = hi_nx;
    if (sgn && s1_q) rem = -rem;
    fin1 = prod[WIDTH-1:0];
    fin2 = prod[2*WIDTH-1:WIDTH];
    if (div) begin
      if (opd_q == '0) begin
        fin1 = '1;
        fin2 = op1_q;
      end else begin
        fin1 = quo;
        fin2 = rem;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (Start) state_d = COMPUTING;
      COMPUTING: if (cnt_q == LAST) state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      op_q   <= '0;
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      op1_q  <= '0;
      opd_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      cnt_q  <= '0;
      res1_q <= '0;
      res2_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start) begin
            op_q  <= MCycleOp;
            s1_q  <= Operand1[WIDTH-1];
            s2_q  <= Operand2[WIDTH-1];
            op1_q <= Operand1;
            hi_q  <= '0;
            cnt_q <= '0;
            if (start_div) begin
              lo_q  <= mag1;
              opd_q <= mag2;
            end else begin
              lo_q  <= mag2;
              opd_q <= mag1;
            end
          end
        end
        COMPUTING: begin
          hi_q  <= hi_nx;
          lo_q  <= lo_nx;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            res1_q <= fin1;
            res2_q <= fin2;
          end
        end
        default: ;
      endcase
    end
  end

  assign Result1 = res1_q;
  assign Result2 = res2_q;
  assign Busy    = RESETn & ((state_q == COMPUTING) | ((state_q == IDLE) & Start));

endmodule

// File: tb/tb_mcycle_unit.sv
module tb_mcycle_unit;

  localparam int W = 32;

  logic          CLK = 1'b0;
  logic          RESETn;
  logic          Start;
  logic [1:0]    MCycleOp;
  logic [W-1:0]  Operand1, Operand2;
  logic [W-1:0]  Result1, Result2;
  logic          Busy;

  mcycle_unit #(.WIDTH(W), .OP_W(2)) dut (
    .CLK      (CLK),
    .RESETn   (RESETn),
    .Start    (Start),
    .MCycleOp (MCycleOp),
    .Operand1 (Operand1),
    .Operand2 (Operand2),
    .Result1  (Result1),
    .Result2  (Result2),
    .Busy     (Busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] r1;
    logic [W-1:0] r2;
  } exp_t;

  exp_t         sb[$];
  int           total = 0;
  int           bad   = 0;
  int           run   = 0;
  bit           prev_busy = 0;
  logic [W-1:0] last1 = '0;
  logic [W-1:0] last2 = '0;

  // Reference: plain 64-bit / integer arithmetic on the operands.
  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t            e;
    longint          p;
    longint unsigned up;
    int              sa, sbv;
    case (op)
      2'b00: begin
        p = longint'($signed(a)) * longint'($signed(b));
        e.r1 = p[31:0];
        e.r2 = p[63:32];
      end
      2'b01: begin
        up = {32'b0, a} * {32'b0, b};
        e.r1 = up[31:0];
        e.r2 = up[63:32];
      end
      2'b10: begin
        if (b == 0) begin
          e.r1 = '1; e.r2 = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.r1 = 32'h8000_0000; e.r2 = '0;
        end else begin
          sa = a; sbv = b;
          e.r1 = sa / sbv;
          e.r2 = sa % sbv;
        end
      end
      default: begin
        if (b == 0) begin
          e.r1 = '1; e.r2 = a;
        end else begin
          e.r1 = a / b;
          e.r2 = a % b;
        end
      end
    endcase
    return e;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Monitor: a 1->0 Busy transition outside reset marks a completed operation.
  task automatic mon_step();
    exp_t e;
    if (!RESETn) begin
      run = 0; prev_busy = 0; last1 = '0; last2 = '0;
    end else begin
      if (Busy) begin
        run++;
        chk("hold_r1", Result1, last1);
        chk("hold_r2", Result2, last2);
      end else if (prev_busy) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done r1=%h r2=%h", Result1, Result2);
        end else begin
          e = sb.pop_front();
          chk("result1", Result1, e.r1);
          chk("result2", Result2, e.r2);
          chk("busy_len", W'(run), W'(W + 1));
          last1 = e.r1; last2 = e.r2;
        end
        run = 0;
      end
      prev_busy = Busy;
    end
  endtask

  task automatic wait_empty(input int limit);
    int n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(posedge CLK); #1; n++;
    end
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL timeout pending=%0d exp=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit scramble);
    int n = 0;
    @(posedge CLK); #1;
    Start = 1'b1; MCycleOp = op; Operand1 = a; Operand2 = b;
    sb.push_back(model(op, a, b));
    @(posedge CLK); #1;
    Start = 1'b0;
    while (sb.size() != 0 && n < 200) begin
      if (scramble) begin
        Operand1 = $urandom; Operand2 = $urandom; MCycleOp = 2'($urandom);
      end
      @(posedge CLK); #1; n++;
    end
    wait_empty(10);
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic [1:0]   op;

    fork
      forever begin
        @(negedge CLK);
        mon_step();
      end
    join_none

    RESETn = 1'b0; Start = 1'b1; MCycleOp = 2'b00; Operand1 = '0; Operand2 = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("busy_in_reset", W'(Busy), '0);
    chk("reset_r1", Result1, '0);
    chk("reset_r2", Result2, '0);
    Start = 1'b0;
    @(posedge CLK); #2;
    RESETn = 1'b1;

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(2'b11, 32'd100, 32'd0, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(2'b10, 32'hFFFF_FFFB, 32'd0, 0);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0);
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 0);

    // Start held high through DONE: two back-to-back operations, no third.
    @(posedge CLK); #1;
    Start = 1'b1; MCycleOp = 2'b01; Operand1 = 32'h1234_5678; Operand2 = 32'h9ABC_DEF0;
    sb.push_back(model(2'b01, 32'h1234_5678, 32'h9ABC_DEF0));
    sb.push_back(model(2'b01, 32'h1234_5678, 32'h9ABC_DEF0));
    repeat (35) @(posedge CLK);
    #1;
    Start = 1'b0;
    wait_empty(100);
    repeat (2) @(posedge CLK);
    #1;
    chk("no_third_op", W'(Busy), '0);

    // Reset during COMPUTING cycle 10.
    @(posedge CLK); #1;
    Start = 1'b1; MCycleOp = 2'b01; Operand1 = $urandom | 32'h1; Operand2 = $urandom | 32'h1;
    sb.push_back(model(2'b01, Operand1, Operand2));
    @(posedge CLK); #1;
    Start = 1'b0;
    repeat (9) @(posedge CLK);
    #2;
    RESETn = 1'b0;
    Start  = 1'b1;
    #1;
    chk("abort_busy", W'(Busy), '0);
    chk("abort_r1", Result1, '0);
    chk("abort_r2", Result2, '0);
    void'(sb.pop_back());
    @(posedge CLK); #1;
    chk("abort_busy_held", W'(Busy), '0);
    Start = 1'b0;
    #1;
    RESETn = 1'b1;
    run_op(2'b01, 32'd6, 32'd7, 0);

    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom);
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = $urandom_range(1, 20);
        2:       b = -$urandom_range(1, 20);
        default: b = $urandom;
      endcase
      if (($urandom & 3) == 0) a = -$urandom_range(0, 1000);
      run_op(op, a, b, (i % 2) == 1);
    end

    repeat (3) @(posedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
